// File: rtl/instr_encoder.sv
// instr_encoder: streaming RISC-V instruction encoder.
// Takes decoded instruction fields over a valid/ready handshake, packs them into a
// 32-bit instruction word and writes the words sequentially into instruction memory.
// A single output register holds the pending write until memory accepts it.

module instr_encoder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2:0]            fmt_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic [31:0]           imm_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FULL  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH+1:0] SLOTS_MAX  = (ADDR_WIDTH + 2)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           wdata_q, wdata_d;

    logic signed [31:0]    imm_s;
    logic                  fits_i, fits_b, fits_j;
    logic [31:0]           enc_word;
    logic                  enc_legal;
    logic [ADDR_WIDTH+1:0] slots_used;
    logic                  space_ok;
    logic                  commit;
    logic                  accept;

    assign imm_s = imm_i;

    // Immediate range checks for the I/S, B and J immediate widths.
    always_comb begin
        fits_i = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
        fits_b = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm_i[0];
        fits_j = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm_i[0];
    end

    // Pack the bundle into its instruction format and decide whether it is legal.
    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b0;
        case (fmt_i)
            3'd0: begin
                enc_word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
                enc_legal = fits_i;
            end
            3'd1: begin
                enc_word  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
                enc_legal = fits_i;
            end
            3'd2: begin
                enc_word  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_REG};
                enc_legal = 1'b1;
            end
            3'd3: begin
                enc_word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], OP_BRANCH};
                enc_legal = fits_b;
            end
            3'd4: begin
                enc_word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_IMM};
                enc_legal = fits_i;
            end
            3'd5: begin
                enc_word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
                enc_legal = fits_j;
            end
            default: begin
                enc_word  = 32'd0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Accept only while running, while the output register is free or draining this
    // cycle, and while committed plus pending words still leave room in memory.
    always_comb begin
        slots_used = {1'b0, count_q} + {{(ADDR_WIDTH + 1){1'b0}}, mem_we_q};
        space_ok   = slots_used < SLOTS_MAX;
        in_ready_o = (state_q == ST_RUN) && (!mem_we_q || mem_ready_i) && space_ok;
        commit     = mem_we_q && mem_ready_i;
        accept     = in_valid_i && in_ready_o;
    end

    // Next-state logic: commit the pending word, then load a new one or flag an error.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        mem_we_d = mem_we_q;
        wdata_d  = wdata_q;

        if (commit) begin
            ptr_d    = ptr_q + PTR_ONE;
            count_d  = count_q + COUNT_ONE;
            mem_we_d = 1'b0;
            if (count_d == COUNT_FULL) begin
                state_d = ST_FULL;
            end
        end

        if (accept) begin
            if (enc_legal) begin
                mem_we_d = 1'b1;
                wdata_d  = enc_word;
            end else begin
                state_d = ST_ERROR;
            end
        end
    end

    // State registers; reset and clear both restart the encoder from an empty memory.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q  <= ST_RUN;
            ptr_q    <= '0;
            count_q  <= '0;
            mem_we_q <= 1'b0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            mem_we_q <= mem_we_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = ptr_q;
    assign mem_wdata_o = wdata_q;
    assign count_o     = count_q;
    assign full_o      = (state_q == ST_FULL);
    assign err_o       = (state_q == ST_ERROR);

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RISC-V instruction encoder. It is the inverse of the control-unit main decoder.
- Accepts instruction fields (format class, registers, funct fields, signed immediate) over a valid/ready handshake.
- Packs the fields into a 32-bit instruction word and writes it sequentially into instruction memory.
- Used by the test/boot loader to build programs in hardware without an external assembler.

Parameters:
ADDR_WIDTH, 8, word-address width of instruction memory; capacity is 2^ADDR_WIDTH words

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous, active-high reset
clear_i  input  1  synchronous restart: same effect as rst_i
in_valid_i  input  1  field bundle valid
in_ready_o  output  1  encoder can accept a bundle this cycle
fmt_i  input  3  format class: 0 LOAD, 1 STORE, 2 REG, 3 BRANCH, 4 IMM, 5 JAL, 6/7 illegal
rd_i  input  5  destination register
rs1_i  input  5  source register 1
rs2_i  input  5  source register 2
funct3_i  input  3  funct3 field
funct7_i  input  7  funct7 field (REG only)
imm_i  input  32  signed byte immediate/offset
mem_we_o  output  1  write strobe; this is the output-valid signal
mem_addr_o  output  ADDR_WIDTH  word address of the pending write
mem_wdata_o  output  32  encoded instruction
mem_ready_i  input  1  memory accepts the write this cycle
count_o  output  ADDR_WIDTH+1  number of words committed to memory
full_o  output  1  memory full
err_o  output  1  sticky illegal-bundle flag

Behaviour:
- Reset and clear (rst_i or clear_i):
  - FSM enters RUN; write pointer = 0.
  - count_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, full_o = 0, err_o = 0.
  - Any pending write is discarded, including one arriving mid-handshake.
- FSM states:
  - RUN: normal operation.
  - FULL: no further accepts; exit only by reset or clear.
  - ERROR: no further accepts; exit only by reset or clear.
- Accept:
  - in_ready_o = (state==RUN) && (!mem_we_o || mem_ready_i) && (pointer + pending < 2^ADDR_WIDTH).
  - A transfer occurs when in_valid_i && in_ready_o.
- Latency: one cycle.
  - A legal bundle accepted in cycle N gives mem_we_o=1 in cycle N+1, with mem_wdata_o = encoded word and mem_addr_o = pointer.
- Output hold:
  - mem_we_o, mem_addr_o and mem_wdata_o stay stable until mem_ready_i=1.
  - On commit: pointer+1, count_o+1.
  - Commit and a new accept may happen in the same cycle, giving back-to-back throughput of 1 word/cycle.
- Full:
  - When count_o reaches 2^ADDR_WIDTH after a commit: full_o=1, state → FULL.
  - The pointer wraps to 0 but is never used again.
- Encoding. The bundle fields fill these positions; each format's opcode goes in bits [6:0]:
  - LOAD: opcode 0000011, I-type: imm[11:0], rs1, funct3, rd.
  - STORE: opcode 0100011, S-type: imm[11:5], rs2, rs1, funct3, imm[4:0].
  - REG: opcode 0110011, R-type: funct7, rs2, rs1, funct3, rd.
  - BRANCH: opcode 1100011, B-type: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11].
  - IMM: opcode 0010011, I-type as LOAD. Shift encodings are the caller's responsibility.
  - JAL: opcode 1101111, J-type: imm[20], imm[10:1], imm[11], imm[19:12], rd.
  - Fields not used by a format are ignored.
- Legality checks, performed at accept:
  - fmt 6/7 is illegal.
  - I/S: imm must be within [-2048, 2047].
  - B: imm must be within [-4096, 4094] and even.
  - J: imm must be within [-1048576, 1048574] and even.
- Illegal bundle:
  - The bundle is consumed (handshake completes) but never written.
  - err_o=1 from the next cycle; state → ERROR.
  - A pending legal write already on the output still completes normally.
- Simultaneous events:
  - rst_i or clear_i overrides all other inputs.
  - An illegal accept in the same cycle as a commit: the commit still counts.

Test Plan:
- Reset, then IMM rd=1 rs1=0 f3=0 imm=5 → mem_we_o next cycle, addr 0, data 0x00500093; with mem_ready_i=1, count_o=1.
- Stream with mem_ready_i held at 1:
  - LOAD rd=2 rs1=1 f3=2 imm=8 → 0x0080A103
  - STORE rs1=1 rs2=2 f3=2 imm=4 → 0x0020A223
  - REG rd=3 rs1=1 rs2=2 f3=0 f7=0 → 0x002081B3
  - Required: addrs 0,1,2 on consecutive cycles, in_ready_o stays 1 throughout.
- BRANCH rs1=1 rs2=2 f3=0 imm=-4 → 0xFE208EE3; JAL rd=1 imm=8 → 0x008000EF.
- Backpressure: hold mem_ready_i=0 for 3 cycles with a word pending → in_ready_o=0, outputs stable; release → single commit, count_o increments by exactly 1.
- Illegal bundles:
  - IMM imm=2048 → no write, err_o=1, in_ready_o=0.
  - After clear_i: BRANCH imm=3 → err_o=1.
  - fmt=7 → err_o=1.
- Fill with ADDR_WIDTH=2: commit 4 words → full_o=1, count_o=4, in_ready_o=0. Pulse clear_i mid-write → all outputs return to reset values.
